fetch_buffer: RTL and testbench

- Instruction-fetch stage directly downstream of the PC stage.
- Consumes the current pc and issues a read to instruction memory, which returns data one cycle later.
- Queues each returned {instr, pc} in a small FIFO and presents it to decode with valid/ready.
- Throttles PC advance when the queue is full; discards all queued and in-flight fetches on a control-flow redirect (flush).

---
 rtl/fetch_buffer.sv | 180 ++++++++++++++++++
 tb/tb_fetch_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Instruction-fetch stage that sits directly after the PC stage. Each cycle
//   it may issue a read of the current pc to instruction memory. The data
//   returns one cycle later and is queued with its pc in a small FIFO, which
//   feeds decode through a valid/ready handshake. Issue is throttled so that
//   queued plus in-flight fetches never exceed DEPTH. A flush discards
//   everything queued and in flight.
//
//   Optional feature (macro FETCH_BYPASS_EN): when the FIFO is empty, a
//   returning fetch is presented to decode in the same cycle it arrives. If
//   decode accepts it there, it is never written to the FIFO.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   pc          current pc from the PC stage
//   flush       redirect: kill queued and in-flight fetches
//   imem_en     fetch request this cycle
//   imem_addr   fetch address (equals pc)
//   imem_rdata  instruction, valid one cycle after imem_en
//   pc_advance  PC stage may update pc this cycle (equals imem_en)
//   d_valid     an entry is presented to decode
//   d_ready     decode accepts the presented entry
//   d_instr     head instruction
//   d_pc        pc of the head instruction
//   d_pcplus4   d_pc + 4, wrapping
//   count       current FIFO occupancy
module fetch_buffer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDRESS_WIDTH-1:0]     pc,
  input  logic                         flush,
  output logic                         imem_en,
  output logic [ADDRESS_WIDTH-1:0]     imem_addr,
  input  logic [DATA_WIDTH-1:0]        imem_rdata,
  output logic                         pc_advance,
  output logic                         d_valid,
  input  logic                         d_ready,
  output logic [DATA_WIDTH-1:0]        d_instr,
  output logic [ADDRESS_WIDTH-1:0]     d_pc,
  output logic [ADDRESS_WIDTH-1:0]     d_pcplus4,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // FIFO storage, split into instruction and pc arrays indexed by pointer.
  logic [DATA_WIDTH-1:0]    mem_instr [DEPTH];
  logic [ADDRESS_WIDTH-1:0] mem_pc    [DEPTH];

  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         count_next;

  logic                     inflight;
  logic [ADDRESS_WIDTH-1:0] inflight_pc;

  logic [CNT_W:0]           reserved;
  logic                     resp_valid;
  logic                     bypass_hit;
  logic                     bypass_take;
  logic                     push;
  logic                     fifo_pop;
  logic                     fifo_nonempty;

  // ---------------------------------------------------------------------------
  // Issue. A request is only allowed when a FIFO slot is still unclaimed by
  // queued entries and the outstanding fetch, so a returning response always
  // has somewhere to go.
  // ---------------------------------------------------------------------------
  assign reserved   = {1'b0, count} + (CNT_W + 1)'(inflight);
  assign imem_en    = !rst && !flush && (reserved < (CNT_W + 1)'(DEPTH));
  assign imem_addr  = pc;
  assign pc_advance = imem_en;

  // A response arriving in a flush cycle belongs to the old path.
  assign resp_valid    = inflight && !flush;
  assign fifo_nonempty = (count != '0);

`ifdef FETCH_BYPASS_EN
  // Empty FIFO: forward the returning fetch straight to decode. It is only
  // written to the FIFO if decode does not take it this cycle.
  assign bypass_hit  = !rst && resp_valid && !fifo_nonempty;
  assign bypass_take = bypass_hit && d_ready;
`else
  assign bypass_hit  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign push     = resp_valid && !bypass_take;
  assign fifo_pop = fifo_nonempty && d_ready && !flush;

  // ---------------------------------------------------------------------------
  // Occupancy. Push and pop together leave count unchanged; the issue
  // reservation means push never lands on a full FIFO.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    count_next = count;
    if (push && !fifo_pop) begin
      count_next = count + CNT_W'(1);
    end else if (!push && fifo_pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Control state: pointers, occupancy and the in-flight flag.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_en;
      count    <= count_next;
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

  // pc of the outstanding request, paired with imem_rdata on its return.
  always_ff @(posedge clk) begin
    if (imem_en) begin
      inflight_pc <= pc;
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and the head outputs are forced to zero while invalid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_instr[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]    <= inflight_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation. Outputs read zero whenever nothing is presented, which
  // also gives the all-zero head after reset.
  // ---------------------------------------------------------------------------
  assign d_valid = !rst && (fifo_nonempty || bypass_hit);

  always_comb begin
    d_instr = '0;
    d_pc    = '0;
    if (d_valid) begin
      if (bypass_hit) begin
        d_instr = imem_rdata;
        d_pc    = inflight_pc;
      end else begin
        d_instr = mem_instr[rd_ptr];
        d_pc    = mem_pc[rd_ptr];
      end
    end
  end

  // Carry out of the top bit is dropped, so 0xFFFF_FFFC + 4 wraps to 0.
  assign d_pcplus4 = d_valid ? (d_pc + ADDRESS_WIDTH'(4)) : '0;

endmodule

// File: tb/tb_fetch_buffer.sv
// Testbench for fetch_buffer. The driver acts as PC stage and instruction
// memory. It queues the expected {instr, pc} for every fetch the buffer should
// issue, and clears that queue on flush or reset. A separate monitor pops the
// queue and compares on every decode handshake. The driver also checks
// occupancy, d_valid and the issue signals each cycle.
module tb_fetch_buffer;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic           clk        = 1'b0;
  logic           rst        = 1'b1;
  logic           flush      = 1'b0;
  logic           d_ready    = 1'b0;
  logic [AW-1:0]  pc         = '0;
  logic [DW-1:0]  imem_rdata = 32'hDEAD_BEEF;

  logic           imem_en;
  logic [AW-1:0]  imem_addr;
  logic           pc_advance;
  logic           d_valid;
  logic [DW-1:0]  d_instr;
  logic [AW-1:0]  d_pc;
  logic [AW-1:0]  d_pcplus4;
  logic [2:0]     count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t exp_q[$];
  entry_t mon_e;
  logic   inflight_m = 1'b0;
  logic   rst_prev   = 1'b1;

  fetch_buffer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .flush      (flush),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .pc_advance (pc_advance),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .d_instr    (d_instr),
    .d_pc       (d_pc),
    .d_pcplus4  (d_pcplus4),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: three real instructions at the bottom,
  // an address-derived pattern elsewhere.
  function automatic logic [DW-1:0] imem_word(input logic [AW-1:0] a);
    case (a)
      32'h0000_0000: imem_word = 32'h0050_0093;
      32'h0000_0004: imem_word = 32'h00A0_0113;
      32'h0000_0008: imem_word = 32'h0020_81B3;
      default:       imem_word = a ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check cycle outputs against the model,
  // record the expected fetch, then play PC stage and memory after the edge.
  task automatic step(input logic r, input logic f, input logic rdy, input logic [AW-1:0] target);
    logic          exp_issue;
    logic          exp_valid;
    logic          byp;
    int            cnt_exp;
    logic          req;
    logic [AW-1:0] req_addr;
    entry_t        e;
    @(negedge clk);
    rst     = r;
    flush   = f;
    d_ready = rdy;
    if (f) pc = target;
    #1;
    cnt_exp = exp_q.size() - int'(inflight_m);
    // In the first cycle of reset, count still shows the pre-reset value.
    if (!(r && !rst_prev)) check("count", count, cnt_exp);
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = (cnt_exp == 0) && inflight_m && !f;
`endif
    exp_valid = !r && ((cnt_exp != 0) || byp);
    exp_issue = !r && !f && (exp_q.size() < DEPTH);
    check("d_valid", d_valid, exp_valid);
    check("imem_en", imem_en, exp_issue);
    check("pc_advance", pc_advance, exp_issue);
    if (exp_issue) check("imem_addr", imem_addr, pc);
    if (r || f) exp_q.delete();
    if (exp_issue) begin
      e.instr = imem_word(pc);
      e.pc    = pc;
      exp_q.push_back(e);
    end
    req      = imem_en;
    req_addr = imem_addr;
    rst_prev = r;
    @(posedge clk);
    #1;
    inflight_m = exp_issue;
    imem_rdata = req ? imem_word(req_addr) : 32'hDEAD_BEEF;
    if (req) pc = pc + 32'd4;
  endtask

  // Monitor: compares every accepted entry with the oldest expected fetch.
  initial begin
    logic [AW-1:0] p4;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !flush && d_valid && d_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_entry: got pc %0h with nothing expected", d_pc);
        end else begin
          mon_e = exp_q.pop_front();
          p4    = mon_e.pc + 32'd4;
          check("d_instr", d_instr, mon_e.instr);
          check("d_pc", d_pc, mon_e.pc);
          check("d_pcplus4", d_pcplus4, p4);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset: head outputs must read zero.
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    check("reset_d_instr", d_instr, 0);
    check("reset_d_pc", d_pc, 0);
    check("reset_d_pcplus4", d_pcplus4, 0);

    // Fetch 0x0, 0x4, 0x8 onward with decode always ready.
    repeat (8) step(1'b0, 1'b0, 1'b1, '0);

    // Decode stalls: FIFO fills, issue stops, then drains one per cycle.
    repeat (8) step(1'b0, 1'b0, 1'b0, '0);
    repeat (6) step(1'b0, 1'b0, 1'b1, '0);

    // Three queued plus one in flight, then redirect to 0x100.
    step(1'b0, 1'b1, 1'b0, 32'h0000_0040);
    repeat (4) step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 32'h0000_0100);
    repeat (6) step(1'b0, 1'b0, 1'b1, '0);

    // Full FIFO, then sustained push/pop with pointer wrap.
    repeat (6) step(1'b0, 1'b0, 1'b0, '0);
    repeat (14) step(1'b0, 1'b0, 1'b1, '0);

    // pc wraps past 0xFFFF_FFFC.
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0);
    repeat (8) step(1'b0, 1'b0, 1'b1, '0);

    // Reset mid-stream with two queued and one in flight.
    step(1'b0, 1'b1, 1'b0, 32'h0000_0200);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    repeat (6) step(1'b0, 1'b0, 1'b1, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
